word_uart_tx: RTL and testbench

Serial transmitter for 24-bit result words. It sits directly downstream of the 24-bit result producer: it accepts one word per valid/ready handshake and sends it on a single UART line as three 8N1 frames, most significant byte first. The line idles high and is reset-safe, so the word producer's reset behaviour can be observed on the lab serial port.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/baud_tick.sv | 35 +++
 rtl/word_uart_tx.sv | 145 ++++++++++++++
 tb/tb_word_uart_tx.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 24-bit word UART transmitter.
// Holds the FSM state enum, frame geometry and a byte-select helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    localparam int FRAME_BITS     = 10;
    localparam int BYTES_PER_WORD = 3;
    localparam int DATA_BITS      = 8;

    // Byte 0 is the most significant byte of the word.
    function automatic logic [7:0] word_byte(
        input logic [23:0] w,
        input logic [1:0]  idx
    );
        logic [7:0] b;
        b = w[7:0];
        unique case (idx)
            2'd0:    b = w[23:16];
            2'd1:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the wrap.
// Ports: clk, rst (sync, active-high), clear (restart at 0), tick (pulse).
module baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/word_uart_tx.sv
// Sends one 24-bit word per valid/ready handshake as three 8N1 frames, MSB byte first.
// Ports: clk, rst (sync, active-high), in_data/in_valid/in_ready, tx, busy, done.
module word_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("word_uart_tx: CLKS_PER_BIT must be >= 2");
    end

    state_e      state_q, state_d;
    logic [23:0] word_q, word_d;
    logic [7:0]  sh_q, sh_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rdy_q, rdy_d;
    logic        clear;
    logic        tick;
    logic [7:0]  cur_byte;

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );

    assign cur_byte = word_byte(word_q, byte_q);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdy_d   = rdy_q;
        clear   = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                rdy_d  = 1'b1;
                if (in_valid && rdy_q) begin
                    word_d  = in_data;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    rdy_d   = 1'b0;
                    byte_d  = '0;
                    bit_d   = '0;
                    // restart the bit timer so the start bit is full length
                    clear   = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = cur_byte[0];
                    sh_d    = cur_byte >> 1;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = sh_q[0];
                        sh_d  = sh_q >> 1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (byte_q < 2'(BYTES_PER_WORD - 1)) begin
                        byte_d  = byte_q + 2'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        rdy_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready = rdy_q;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_word_uart_tx.sv
// Directed testbench for word_uart_tx with CLKS_PER_BIT=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_word_uart_tx;
    import uart_pkg::*;

    localparam int CPB      = 4;
    localparam int WORD_CYC = FRAME_BITS * BYTES_PER_WORD * CPB;

    // Serial frames in transmit order, first bit at the MSB.
    localparam logic [29:0] F_C0FFEE = 30'b0000000111_0111111111_0011101111;
    localparam logic [29:0] F_000000 = 30'b0000000001_0000000001_0000000001;
    localparam logic [29:0] F_FFFFFF = 30'b0111111111_0111111111_0111111111;
    localparam logic [29:0] F_A5A5A5 = 30'b0101001011_0101001011_0101001011;
    localparam logic [29:0] F_5A3C96 = 30'b0010110101_0001111001_0011010011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_ready;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    word_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    function automatic logic [119:0] expand(input logic [29:0] f);
        logic [119:0] w;
        w = '0;
        for (int i = 0; i < 30; i++) begin
            for (int r = 0; r < CPB; r++) begin
                w[119 - (CPB * i + r)] = f[29 - i];
            end
        end
        return w;
    endfunction

    // Called at a falling edge; returns just after the accepting rising edge.
    task automatic send(input logic [23:0] d);
        int t;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
    endtask

    // Observes cycles k+1 .. k+121 after an accept at edge k.
    task automatic capture(
        input  bit           hold,
        input  logic [23:0]  nd,
        input  int           poke_n,
        output logic [119:0] wave,
        output int           done_n,
        output int           done_cnt,
        output int           ctl_bad,
        output logic         rdy_end,
        output logic         tx_end
    );
        wave     = '0;
        done_n   = -1;
        done_cnt = 0;
        ctl_bad  = 0;
        rdy_end  = 1'b0;
        tx_end   = 1'b0;
        for (int n = 1; n <= WORD_CYC + 1; n++) begin
            @(negedge clk);
            if (n <= WORD_CYC) begin
                wave[WORD_CYC - n] = tx;
                if (busy !== 1'b1 || in_ready !== 1'b0) ctl_bad++;
            end else begin
                if (busy !== 1'b0) ctl_bad++;
                rdy_end = in_ready;
                tx_end  = tx;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_n = n;
            end
            if (n == 1) begin
                in_valid = hold;
                in_data  = nd;
            end
            if (n == poke_n) begin
                in_valid = 1'b1;
                in_data  = 24'h123456;
            end
            if (n == poke_n + 1) begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 24'hc0ffee;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, in_ready, busy, done} !== 4'b1000) begin
                errors++;
                $display("FAIL reset_hold: {tx,rdy,busy,done}=%b required 1000",
                         {tx, in_ready, busy, done});
            end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b busy=%b required 1 0",
                     in_ready, busy);
        end
    endtask

    task automatic test_single();
        logic [119:0] w;
        logic [29:0]  mid;
        int           dn, dc, cb;
        logic         re, te;
        send(24'hc0ffee);
        capture(1'b0, 24'h0, -10, w, dn, dc, cb, re, te);
        for (int j = 0; j < 30; j++) mid[29 - j] = w[WORD_CYC - (CPB * j + 2)];
        checks++;
        if (mid !== F_C0FFEE) begin
            errors++;
            $display("FAIL single_bits: got %b required %b", mid, F_C0FFEE);
        end
        checks++;
        if (dn !== WORD_CYC + 1 || dc !== 1) begin
            errors++;
            $display("FAIL single_done: at %0d count %0d required %0d 1",
                     dn, dc, WORD_CYC + 1);
        end
        checks++;
        if (cb !== 0 || re !== 1'b1 || te !== 1'b1) begin
            errors++;
            $display("FAIL single_ctl: bad=%0d rdy=%b tx=%b required 0 1 1",
                     cb, re, te);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL single_after: done=%b tx=%b required 0 1", done, tx);
        end
    endtask

    task automatic test_back_to_back();
        logic [119:0] w1, w2;
        int           dn1, dc1, cb1, dn2, dc2, cb2;
        logic         re1, te1, re2, te2;
        send(24'h000000);
        capture(1'b1, 24'hffffff, -10, w1, dn1, dc1, cb1, re1, te1);
        @(posedge clk);
        capture(1'b0, 24'h0, -10, w2, dn2, dc2, cb2, re2, te2);
        checks++;
        if (w1 !== expand(F_000000)) begin
            errors++;
            $display("FAIL b2b_word0: got %h required %h", w1, expand(F_000000));
        end
        checks++;
        if (w2 !== expand(F_FFFFFF)) begin
            errors++;
            $display("FAIL b2b_word1: got %h required %h", w2, expand(F_FFFFFF));
        end
        checks++;
        if (te1 !== 1'b1 || re1 !== 1'b1 || w2[119:116] !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_gap: idle_tx=%b rdy=%b start=%b required 1 1 0000",
                     te1, re1, w2[119:116]);
        end
        checks++;
        if (dc1 + dc2 !== 2 || dn1 !== WORD_CYC + 1 || dn2 !== WORD_CYC + 1) begin
            errors++;
            $display("FAIL b2b_done: count=%0d at %0d,%0d required 2 at %0d",
                     dc1 + dc2, dn1, dn2, WORD_CYC + 1);
        end
        checks++;
        if (cb1 !== 0 || cb2 !== 0) begin
            errors++;
            $display("FAIL b2b_busy: bad=%0d,%0d required 0,0", cb1, cb2);
        end
    endtask

    task automatic test_busy_reject();
        logic [119:0] w;
        int           dn, dc, cb, bad;
        logic         re, te;
        send(24'hc0ffee);
        capture(1'b0, 24'h0, 50, w, dn, dc, cb, re, te);
        checks++;
        if (w !== expand(F_C0FFEE) || dn !== WORD_CYC + 1 || dc !== 1) begin
            errors++;
            $display("FAIL busy_reject_word: done at %0d count %0d wave %h",
                     dn, dc, w);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL busy_reject_extra: bad=%0d required 0", bad);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [119:0] w;
        int           dn, dc, cb, bad;
        logic         re, te;
        send(24'h123456);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (48) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_pre: tx=%b required 0", tx);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({tx, busy, done, in_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL rst_mid_edge: {tx,busy,done,rdy}=%b required 1000",
                     {tx, busy, done, in_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_quiet: bad=%0d rdy=%b required 0 1",
                     bad, in_ready);
        end
        send(24'ha5a5a5);
        capture(1'b0, 24'h0, -10, w, dn, dc, cb, re, te);
        checks++;
        if (w !== expand(F_A5A5A5) || dn !== WORD_CYC + 1 || dc !== 1) begin
            errors++;
            $display("FAIL rst_mid_resume: done at %0d count %0d wave %h",
                     dn, dc, w);
        end
    endtask

    task automatic test_bit_timing();
        logic [119:0] w;
        int           dn, dc, cb, run, bad_runs;
        logic         re, te;
        send(24'h5a3c96);
        capture(1'b0, 24'h0, -10, w, dn, dc, cb, re, te);
        bad_runs = 0;
        run      = 1;
        for (int n = 118; n >= 0; n--) begin
            if (w[n] === w[n + 1]) begin
                run++;
            end else begin
                if (run % CPB != 0) bad_runs++;
                run = 1;
            end
        end
        if (run % CPB != 0) bad_runs++;
        checks++;
        if (bad_runs !== 0) begin
            errors++;
            $display("FAIL timing_runs: bad runs=%0d required 0", bad_runs);
        end
        checks++;
        if (dn - 1 !== WORD_CYC) begin
            errors++;
            $display("FAIL timing_total: cycles=%0d required %0d", dn - 1, WORD_CYC);
        end
        checks++;
        if (w !== expand(F_5A3C96)) begin
            errors++;
            $display("FAIL timing_wave: got %h required %h", w, expand(F_5A3C96));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_reject();
        test_reset_mid_word();
        test_bit_timing();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
